// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer and the control unit:
// sequencer state encoding and the instruction word layout.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 16;

    // Instruction field positions
    localparam int unsigned DEST_LSB = 13;
    localparam int unsigned SRC_LSB  = 10;
    localparam int unsigned ALU_LSB  = 3;
    localparam int unsigned MODE_BIT = 2;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned ALU_W    = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StFin   = 3'd3,
        StErr   = 3'd4
    } seq_state_e;

    // Packed view of an instruction word; bits [9:7] and [1:0] are reserved.
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src;
        logic [2:0]       rsvd_hi;
        logic [ALU_W-1:0] alu_sel;
        logic             mode;
        logic [1:0]       rsvd_lo;
    } instr_t;

    function automatic logic [REG_W-1:0] instr_dest(input logic [INSTR_W-1:0] word);
        return word[DEST_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] instr_src(input logic [INSTR_W-1:0] word);
        return word[SRC_LSB +: REG_W];
    endfunction

    function automatic logic [ALU_W-1:0] instr_alu_sel(input logic [INSTR_W-1:0] word);
        return word[ALU_LSB +: ALU_W];
    endfunction

    function automatic logic instr_mode(input logic [INSTR_W-1:0] word);
        return word[MODE_BIT];
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: DEPTH x WIDTH, synchronous write, asynchronous read.
// Contents are intentionally not reset.
module prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps through a loaded program, handing one word at
// a time to the control unit and waiting (with timeout) for its completion.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INSTR_W-1:0]       load_data,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     start,
    input  logic                     cu_done,
    output logic                     cu_run,
    output logic [INSTR_W-1:0]       instruction,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     finished,
    output logic                     error
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [LW-1:0] MaxLen   = LW'(DEPTH);
    localparam logic [CW-1:0] WaitLast = CW'(TIMEOUT - 1);

    seq_state_e        state;
    seq_state_e        state_next;
    logic [AW-1:0]     pc_next;
    logic [LW-1:0]     len;
    logic [LW-1:0]     len_next;
    logic [LW-1:0]     len_clamped;
    logic [CW-1:0]     wait_cnt;
    logic              accept;
    logic              last_instr;
    logic              wait_expired;
    logic              mem_we;
    logic [INSTR_W-1:0] rd_data;

    // Start and program loads are only honoured while parked (idle or error).
    assign accept       = start && ((state == StIdle) || (state == StErr));
    assign mem_we       = load_en && ((state == StIdle) || (state == StErr));
    assign len_clamped  = (prog_len > MaxLen) ? MaxLen : prog_len;
    assign last_instr   = ({1'b0, pc} == (len - LW'(1)));
    assign wait_expired = (wait_cnt == WaitLast);

    // Read address follows next pc so the word is registered on entry to issue.
    prog_mem #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_next),
        .rdata (rd_data)
    );

    // Next-state, next-pc and length latch selection
    always_comb begin
        state_next = state;
        pc_next    = pc;
        len_next   = len;
        case (state)
            StIdle, StErr: begin
                if (accept) begin
                    pc_next    = '0;
                    len_next   = len_clamped;
                    state_next = (len_clamped == '0) ? StFin : StIssue;
                end
            end
            StIssue: begin
                state_next = StWait;
            end
            StWait: begin
                // Completion takes priority over an expiring timeout.
                if (cu_done) begin
                    if (last_instr) begin
                        state_next = StFin;
                    end else begin
                        pc_next    = pc + AW'(1);
                        state_next = StIssue;
                    end
                end else if (wait_expired) begin
                    state_next = StErr;
                end
            end
            StFin: begin
                state_next = StIdle;
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // State register and registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            pc          <= '0;
            len         <= '0;
            wait_cnt    <= '0;
            instruction <= '0;
            cu_run      <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            error       <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            len      <= len_next;
            cu_run   <= (state_next == StIssue);
            busy     <= (state_next == StIssue) || (state_next == StWait);
            finished <= (state_next == StFin);
            if (state_next == StIssue) begin
                instruction <= rd_data;
            end
            // Counts cycles already spent in wait; restarts on every new wait.
            if ((state == StWait) && (state_next == StWait)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (accept) begin
                error <= 1'b0;
            end else if ((state == StWait) && (state_next == StErr)) begin
                error <= 1'b1;
            end
        end
    end

endmodule
